// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 4-bit ALU.
// Accepts one operation at a time and executes it from captured operands.
// The response is held until the consumer takes it.
module alu_arbiter #(
    parameter logic PRIO_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_out,
    output logic       rsp_carry
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StHold
    } state_e;

    state_e     state_q;
    logic       rr_ptr_q;
    logic [3:0] op_a_q;
    logic [3:0] op_b_q;
    logic [2:0] op_sel_q;
    logic       op_id_q;

    logic       grant_valid;
    logic       grant_id;
    logic [4:0] alu_res;

    // Grant in IDLE only; a contested cycle goes to rr_ptr, a lone requester always wins.
    always_comb begin
        grant_valid = rst_n && (state_q == StIdle) && (req0_valid || req1_valid);
        grant_id    = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
        req0_ready  = grant_valid && !grant_id;
        req1_ready  = grant_valid && grant_id;
    end

    // Shared ALU, fed only from the captured operand registers; bit 4 is carry/borrow.
    always_comb begin
        alu_res = 5'd0;
        case (op_sel_q)
            3'b000:  alu_res = {1'b0, op_a_q} + {1'b0, op_b_q};
            3'b001:  alu_res = {1'b0, op_a_q} - {1'b0, op_b_q};
            3'b010:  alu_res = {1'b0, op_a_q & op_b_q};
            3'b011:  alu_res = {1'b0, op_a_q | op_b_q};
            3'b100:  alu_res = {1'b0, op_a_q ^ op_b_q};
            3'b101:  alu_res = {1'b0, ~op_a_q};
            default: alu_res = 5'd0;
        endcase
    end

    // Control FSM with registered response outputs; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= PRIO_RESET;
            op_a_q    <= 4'd0;
            op_b_q    <= 4'd0;
            op_sel_q  <= 3'd0;
            op_id_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_out   <= 4'd0;
            rsp_carry <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        op_a_q   <= grant_id ? req1_a : req0_a;
                        op_b_q   <= grant_id ? req1_b : req0_b;
                        op_sel_q <= grant_id ? req1_sel : req0_sel;
                        op_id_q  <= grant_id;
                        rr_ptr_q <= !grant_id;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    rsp_out   <= alu_res[3:0];
                    rsp_carry <= alu_res[4];
                    rsp_id    <= op_id_q;
                    rsp_valid <= 1'b1;
                    state_q   <= StHold;
                end
                StHold: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_sel, req1_sel;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [3:0] rsp_out;

    alu_arbiter #(
        .PRIO_RESET(1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_sel  (req0_sel),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_sel  (req1_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_carry (rsp_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Requester-side pending operations and consumer readiness.
    logic       p_valid [2];
    logic [3:0] p_a     [2];
    logic [3:0] p_b     [2];
    logic [2:0] p_sel   [2];
    logic       c_ready;

    // Transaction-level model: one operation in flight, response two edges after accept.
    logic       m_busy, m_rsp_v, m_rr;
    logic       pend_id, m_id;
    logic [4:0] pend_res, m_res;
    int         grants[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_alu(input int a, input int b, input int sel);
        int o;
        int r;
        logic c;
        c = 1'b0;
        o = 0;
        case (sel)
            0: begin r = a + b; o = r % 16; c = (r > 15); end
            1: begin o = (a - b + 16) % 16; c = (a < b); end
            2: o = a & b;
            3: o = a | b;
            4: o = a ^ b;
            5: o = 15 - a;
            default: o = 0;
        endcase
        return {c, 4'(o)};
    endfunction

    task automatic arm(input int i, input int a, input int b, input int sel);
        p_valid[i] = 1'b1;
        p_a[i]     = 4'(a);
        p_b[i]     = 4'(b);
        p_sel[i]   = 3'(sel);
    endtask

    task automatic arm_rand(input int i);
        arm(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
    endtask

    // One clock cycle: drive, check outputs, then advance the model across the edge.
    task automatic step();
        logic g_valid, g_id;
        req0_valid = p_valid[0]; req0_a = p_a[0]; req0_b = p_b[0]; req0_sel = p_sel[0];
        req1_valid = p_valid[1]; req1_a = p_a[1]; req1_b = p_b[1]; req1_sel = p_sel[1];
        rsp_ready  = c_ready;
        #1;
        g_valid = !m_busy && !m_rsp_v && (p_valid[0] || p_valid[1]);
        g_id    = (p_valid[0] && p_valid[1]) ? m_rr : p_valid[1];
        check("req0_ready", 32'(req0_ready), 32'(g_valid && !g_id));
        check("req1_ready", 32'(req1_ready), 32'(g_valid && g_id));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
        if (m_rsp_v) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_out", 32'(rsp_out), 32'(m_res[3:0]));
            check("rsp_carry", 32'(rsp_carry), 32'(m_res[4]));
        end
        @(posedge clk);
        if (m_rsp_v) begin
            if (c_ready) m_rsp_v = 1'b0;
        end else if (m_busy) begin
            m_busy  = 1'b0;
            m_rsp_v = 1'b1;
            m_id    = pend_id;
            m_res   = pend_res;
        end else if (g_valid) begin
            m_busy   = 1'b1;
            pend_id  = g_id;
            pend_res = ref_alu(int'(p_a[g_id]), int'(p_b[g_id]), int'(p_sel[g_id]));
            m_rr     = !g_id;
            p_valid[g_id] = 1'b0;
            grants.push_back(int'(g_id));
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse mid-cycle with both valids raised to prove readies stay low.
    task automatic do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_out", 32'(rsp_out), 32'd0);
        check("rst_rsp_carry", 32'(rsp_carry), 32'd0);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        m_busy  = 1'b0;
        m_rsp_v = 1'b0;
        m_rr    = 1'b0;
        @(negedge clk);
        #1;
        check("rst_hold_valid", 32'(rsp_valid), 32'd0);
        check("rst_hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        c_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!m_busy && !m_rsp_v && !p_valid[0] && !p_valid[1]) break;
            step();
        end
        check("drain_idle", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        c_ready = 1'b0;
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
        for (int i = 0; i < 2; i++) begin
            p_valid[i] = 1'b0; p_a[i] = '0; p_b[i] = '0; p_sel[i] = '0;
        end
        m_busy = 1'b0; m_rsp_v = 1'b0; m_rr = 1'b0;
        pend_id = 1'b0; pend_res = '0; m_id = 1'b0; m_res = '0;
        @(negedge clk);
        do_reset();

        // Lone ADD F+1 wraps to 0 with carry.
        arm(0, 15, 1, 0);
        c_ready = 1'b0;
        step();
        step();
        check("add_valid", 32'(rsp_valid), 32'd1);
        check("add_out", 32'(rsp_out), 32'h0);
        check("add_carry", 32'(rsp_carry), 32'd1);
        check("add_id", 32'(rsp_id), 32'd0);
        drain();

        // Contested after reset: requester 0 first, then requester 1's borrow.
        do_reset();
        arm(0, 12, 10, 2);
        arm(1, 3, 5, 1);
        c_ready = 1'b1;
        step();
        step();
        check("and_id", 32'(rsp_id), 32'd0);
        check("and_out", 32'(rsp_out), 32'h8);
        check("and_carry", 32'(rsp_carry), 32'd0);
        step();
        step();
        step();
        check("sub_id", 32'(rsp_id), 32'd1);
        check("sub_out", 32'(rsp_out), 32'hE);
        check("sub_carry", 32'(rsp_carry), 32'd1);
        drain();

        // Backpressure: response held five cycles while both requesters wait.
        arm_rand(0);
        arm_rand(1);
        c_ready = 1'b0;
        for (int k = 0; k < 7; k++) step();
        c_ready = 1'b1;
        step();
        step();
        drain();

        // Illegal op code still returns a zero response tagged with its requester.
        arm(1, 7, 7, 6);
        c_ready = 1'b0;
        step();
        step();
        check("ill_out", 32'(rsp_out), 32'h0);
        check("ill_carry", 32'(rsp_carry), 32'd0);
        check("ill_id", 32'(rsp_id), 32'd1);
        drain();

        // Reset in HOLD with rr_ptr pointing at 1: the next contested grant returns to 0.
        arm_rand(0);
        c_ready = 1'b0;
        step();
        step();
        arm_rand(0);
        arm_rand(1);
        do_reset();
        grants.delete();
        step();
        check("post_rst_grants", 32'(grants.size()), 32'd1);
        if (grants.size() > 0) check("post_rst_grant", 32'(grants[0]), 32'd0);
        step();
        check("post_rst_rsp", 32'(rsp_valid), 32'd1);
        drain();

        // Six back-to-back contested operations alternate, then req0 alone wins every IDLE.
        do_reset();
        grants.delete();
        c_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (grants.size() >= 6) break;
            if (!p_valid[0]) arm_rand(0);
            if (!p_valid[1]) arm_rand(1);
            step();
        end
        check("alt_count", 32'(grants.size()), 32'd6);
        for (int k = 0; k < grants.size(); k++) check("alt_grant", 32'(grants[k]), 32'(k % 2));
        drain();
        grants.delete();
        for (int k = 0; k < 21; k++) begin
            if (!p_valid[0]) arm_rand(0);
            step();
        end
        check("solo_count", 32'(grants.size()), 32'd7);
        for (int k = 0; k < grants.size(); k++) check("solo_grant", 32'(grants[k]), 32'd0);
        drain();

        // Random traffic with random backpressure and occasional resets.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_valid[i] && ($urandom_range(0, 2) == 0)) arm_rand(i);
            end
            c_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
